// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the XNOR LFSR generator.
// Mode encodings, lock-up value function and default maximal taps.
package lfsr_pkg;

  localparam logic LFSR_FIB = 1'b0;
  localparam logic LFSR_GAL = 1'b1;

  localparam logic [1:0] TAPS_W2 = 2'b11;
  localparam logic [3:0] TAPS_W4 = 4'b1100;

  // All-ones is the XNOR fixed point; returned right-aligned in 32 bits.
  function automatic logic [31:0] lfsr_ones(input int w);
    logic [31:0] v;
    v = '1;
    return v >> (32 - w);
  endfunction

endpackage

// File: rtl/lfsr_xnor_gen_next.sv
// Combinational next-state for the XNOR LFSR (Fibonacci or Galois).
// Ports: cur (state in), mode (0 fib / 1 gal), nxt (next state out).
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1100
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt
);

  logic fb;

  always_comb begin
    fb  = ~^(cur & TAPS);
    nxt = {cur[WIDTH-2:0], fb};
    if (mode == LFSR_GAL) begin
      nxt[0] = cur[WIDTH-1];
      for (int i = 1; i < WIDTH; i++) begin
        nxt[i] = TAPS[i-1] ? ~(cur[i-1] ^ cur[WIDTH-1])
                           : cur[i-1];
      end
    end
  end

endmodule

// File: rtl/lfsr_xnor_gen.sv
// Parametrised XNOR LFSR with seed load, lock-up guard and wrap detect.
// Ports: clk, rst, en, load, seed, mode -> out, step_cnt, wrap, lockup.
module lfsr_xnor_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1100,
  parameter logic [WIDTH-1:0] RESET_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] step_cnt,
  output logic             wrap,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(lfsr_ones(WIDTH));

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_xnor_gen: WIDTH must be 2..32");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_xnor_gen: TAPS MSB must be set");
  end
  if (RESET_SEED == ONES) begin : g_bad_seed
    $error("lfsr_xnor_gen: RESET_SEED is the lock-up state");
  end

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ref_seed;

  lfsr_next #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) u_next (
    .cur (out),
    .mode(mode),
    .nxt (nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= RESET_SEED;
      ref_seed <= RESET_SEED;
      step_cnt <= '0;
      wrap     <= 1'b0;
      lockup   <= 1'b0;
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (load) begin
        step_cnt <= '0;
        // An all-ones seed would freeze the sequence; substitute zero.
        if (seed == ONES) begin
          out      <= '0;
          ref_seed <= '0;
          lockup   <= 1'b1;
        end else begin
          out      <= seed;
          ref_seed <= seed;
        end
      end else if (en) begin
        out <= nxt;
        if (nxt == ref_seed) begin
          step_cnt <= '0;
          wrap     <= 1'b1;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_xnor_gen.sv
// Directed self-checking bench for lfsr_xnor_gen.
// Covers a 4-bit instance and a 2-bit legacy-equivalent instance.
module tb_lfsr_xnor_gen;

  logic       clk = 1'b0;
  logic       rst, en, load, mode;
  logic [3:0] seed;
  logic [3:0] out, step_cnt;
  logic       wrap, lockup;

  logic       rst2, en2;
  logic [1:0] out2, cnt2;
  logic       wrap2, lock2;

  int checks = 0;
  int errors = 0;

  logic [3:0] fib_tbl [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE,
                               4'hD, 4'hB, 4'h6, 4'hC, 4'h9,
                               4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

  always #5 clk = ~clk;

  lfsr_xnor_gen #(
    .WIDTH(4), .TAPS(4'b1100), .RESET_SEED(4'h0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .seed(seed), .mode(mode), .out(out),
    .step_cnt(step_cnt), .wrap(wrap), .lockup(lockup)
  );

  lfsr_xnor_gen #(
    .WIDTH(2), .TAPS(2'b11), .RESET_SEED(2'b00)
  ) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .load(1'b0),
    .seed(2'b00), .mode(1'b0), .out(out2),
    .step_cnt(cnt2), .wrap(wrap2), .lockup(lock2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    en = 1'b0; en2 = 1'b0;
    load = 1'b0; seed = '0; mode = 1'b0;
    tick();
    checks++;
    if (out !== 4'h0 || step_cnt !== 4'h0 ||
        wrap !== 1'b0 || lockup !== 1'b0) begin
      errors++;
      $display("FAIL reset out=%h cnt=%h wrap=%b lock=%b exp 0/0/0/0",
               out, step_cnt, wrap, lockup);
    end
  endtask

  task automatic test_legacy();
    logic [1:0] exp_o [3] = '{2'b01, 2'b10, 2'b00};
    logic [1:0] exp_c [3] = '{2'd1, 2'd2, 2'd0};
    checks++;
    if (out2 !== 2'b00 || cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL legacy_rst out=%b cnt=%0d exp 00/0", out2, cnt2);
    end
    rst2 = 1'b0;
    en2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out2 !== exp_o[k] || cnt2 !== exp_c[k] ||
          wrap2 !== (k == 2)) begin
        errors++;
        $display("FAIL legacy step%0d out=%b cnt=%0d wrap=%b exp %b/%0d/%b",
                 k, out2, cnt2, wrap2, exp_o[k], exp_c[k], k == 2);
      end
    end
    en2 = 1'b0;
  endtask

  task automatic test_fib();
    int wraps = 0;
    do_reset();
    mode = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (wrap) wraps++;
      checks++;
      if (out !== fib_tbl[k % 15] ||
          step_cnt !== 4'(k % 15) ||
          wrap !== (k % 15 == 0)) begin
        errors++;
        $display("FAIL fib step%0d out=%h cnt=%h wrap=%b exp %h/%h/%b",
                 k, out, step_cnt, wrap, fib_tbl[k % 15],
                 4'(k % 15), k % 15 == 0);
      end
    end
    checks++;
    if (wraps != 2) begin
      errors++;
      $display("FAIL fib_wraps got %0d exp 2", wraps);
    end
    en = 1'b0;
  endtask

  task automatic test_galois();
    logic [3:0] exp_o [3] = '{4'h8, 4'h1, 4'hA};
    do_reset();
    mode = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out !== exp_o[k]) begin
        errors++;
        $display("FAIL galois step%0d out=%h exp %h", k, out, exp_o[k]);
      end
    end
    en = 1'b0;
    mode = 1'b0;
  endtask

  task automatic test_lockup();
    do_reset();
    mode = 1'b0;
    en = 1'b1;
    tick();
    tick();
    load = 1'b1;
    seed = 4'hF;
    tick();
    checks++;
    if (out !== 4'h0 || lockup !== 1'b1 || step_cnt !== 4'h0) begin
      errors++;
      $display("FAIL lockup_load out=%h lock=%b cnt=%h exp 0/1/0",
               out, lockup, step_cnt);
    end
    seed = 4'h5;
    tick();
    checks++;
    if (out !== 4'h5 || lockup !== 1'b0 || step_cnt !== 4'h0) begin
      errors++;
      $display("FAIL load_en out=%h lock=%b cnt=%h exp 5/0/0",
               out, lockup, step_cnt);
    end
    load = 1'b0;
    en = 1'b0;
    tick();
    checks++;
    if (out !== 4'h5 || lockup !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL hold out=%h lock=%b wrap=%b exp 5/0/0",
               out, lockup, wrap);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] hold_v;
    mode = 1'b0;
    load = 1'b1;
    seed = 4'h7;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      en = 1'b1;
      tick();
      checks++;
      if (out !== fib_tbl[(3 + k) % 15] ||
          step_cnt !== 4'(k % 15) || wrap !== (k == 15)) begin
        errors++;
        $display("FAIL gap step%0d out=%h cnt=%h wrap=%b exp %h/%h/%b",
                 k, out, step_cnt, wrap, fib_tbl[(3 + k) % 15],
                 4'(k % 15), k == 15);
      end
      hold_v = out;
      en = 1'b0;
      tick();
      checks++;
      if (out !== hold_v || wrap !== 1'b0) begin
        errors++;
        $display("FAIL gap_idle%0d out=%h wrap=%b exp %h/0",
                 k, out, wrap, hold_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_o [2] = '{4'h1, 4'h3};
    mode = 1'b0;
    load = 1'b1;
    seed = 4'h6;
    tick();
    load = 1'b0;
    en = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 4'h0 || step_cnt !== 4'h0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_rst out=%h cnt=%h wrap=%b exp 0/0/0",
               out, step_cnt, wrap);
    end
    #2;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (out !== exp_o[k]) begin
        errors++;
        $display("FAIL restart step%0d out=%h exp %h", k, out, exp_o[k]);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_fib();
    test_galois();
    test_lockup();
    test_gaps();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
